// File: rtl/sub_arb_pkg.sv
// Shared types and constants for the round-robin shared subtractor.
// Optional feature macro: SUB_ARB_ABS_EN (S1 captures |a - b| when a < b).
package sub_arb_pkg;
  localparam int SUB_W    = 20;
  localparam int NREQ_DEF = 4;
  localparam int ID_W_MAX = 3;  // enough for the largest supported NREQ (8)

  // S0 payload: operand register
  typedef struct packed {
    logic [ID_W_MAX-1:0] id;
    logic [SUB_W-1:0]    a;
    logic [SUB_W-1:0]    b;
  } op_t;

  // S1 payload: result register
  typedef struct packed {
    logic [ID_W_MAX-1:0] id;
    logic [SUB_W-1:0]    diff;
    logic                ge;
  } res_t;

  // Two's complement negate, used for the absolute-value option
  function automatic logic [SUB_W-1:0] neg_w(input logic [SUB_W-1:0] x);
    return ~x + SUB_W'(1);
  endfunction
endpackage

// File: rtl/sub_share_arb_csel_sub.sv
// Existing 20-bit carry-select subtractor: a + twos(b), split 10/10.
// co is the adder carry-out; twos(0) truncates to 0, so co = 0 for b = 0.
module csel_sub20 (
  input  logic [19:0] a,
  input  logic [19:0] b,
  output logic [19:0] diff,
  output logic        co
);
  logic [19:0] nb;
  logic [10:0] lo, hi0, hi1;

  assign nb  = ~b + 20'd1;
  assign lo  = {1'b0, a[9:0]}   + {1'b0, nb[9:0]};
  assign hi0 = {1'b0, a[19:10]} + {1'b0, nb[19:10]};
  assign hi1 = {1'b0, a[19:10]} + {1'b0, nb[19:10]} + 11'd1;
  assign {co, diff} = {(lo[10] ? hi1 : hi0), lo[9:0]};
endmodule

// File: rtl/sub_share_arb_rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr, wrapping.
// Produces a one-hot grant plus its encoded index; all zero when disabled.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);
  logic found;
  int   j;

  // Rotating priority search starting at the pointer
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (en && !found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDW'(j);
      end
    end
  end
endmodule

// File: rtl/sub_share_arb.sv
// Shares one 20-bit carry-select subtractor between NREQ requesters.
// S0 = operand register, S1 = result register driving rsp_*.
// Optional feature macro: SUB_ARB_ABS_EN (rsp_diff = |a - b|, rsp_ge keeps sign).
module sub_share_arb
  import sub_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = SUB_W,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_diff,
  output logic                  rsp_ge
);
  logic            op_valid;
  op_t             op;
  res_t            s1;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  grant_idx;
  logic [NREQ-1:0] grant;
  logic            s1_free, s0_load, xfer;
  logic [WIDTH-1:0] sub_diff, cap_diff;
  logic            sub_co, sub_ge;
  logic            unused_id;

  assign s1_free = !rsp_valid || rsp_ready;
  assign s0_load = !op_valid || s1_free;
  // Gating with rst_n keeps req_ready low while reset is held
  assign req_ready = grant;
  assign xfer      = |(req_valid & grant);

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .en    (s0_load && rst_n),
    .grant (grant),
    .idx   (grant_idx)
  );

  csel_sub20 u_sub (
    .a    (op.a),
    .b    (op.b),
    .diff (sub_diff),
    .co   (sub_co)
  );

  // Carry-out misses b == 0 (twos(0) == 0), so patch it here
  assign sub_ge = sub_co || (op.b == '0);

`ifdef SUB_ARB_ABS_EN
  assign cap_diff = sub_ge ? sub_diff : neg_w(sub_diff);
`else
  assign cap_diff = sub_diff;
`endif

  // S0 operand stage and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid <= 1'b0;
      op       <= '0;
      ptr      <= '0;
    end else if (s0_load) begin
      op_valid <= xfer;
      if (xfer) begin
        op.id <= ID_W_MAX'(grant_idx);
        op.a  <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
        op.b  <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
        ptr   <= (int'(grant_idx) == NREQ-1) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // S1 result stage; holds everything while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      s1        <= '0;
    end else if (s1_free) begin
      rsp_valid <= op_valid;
      if (op_valid) begin
        s1.id   <= op.id;
        s1.diff <= cap_diff;
        s1.ge   <= sub_ge;
      end
    end
  end

  assign rsp_id    = s1.id[IDW-1:0];
  assign rsp_diff  = s1.diff;
  assign rsp_ge    = s1.ge;
  // Upper ID bits stay zero when NREQ < 8
  assign unused_id = ^s1.id;
endmodule
